// File: rtl/vie_cp0_pkg.sv
// Shared CP0 register addresses, exception codes and commit_exc bit positions
// for the vie_cp0 commit unit.
package vie_cp0_pkg;

    localparam int VIE_CP0_ADDR_W = 8;

    // {rd[4:0], sel[2:0]}
    localparam logic [VIE_CP0_ADDR_W-1:0] CR_BADVADDR = {5'd8,  3'd0};
    localparam logic [VIE_CP0_ADDR_W-1:0] CR_COUNT    = {5'd9,  3'd0};
    localparam logic [VIE_CP0_ADDR_W-1:0] CR_COMPARE  = {5'd11, 3'd0};
    localparam logic [VIE_CP0_ADDR_W-1:0] CR_STATUS   = {5'd12, 3'd0};
    localparam logic [VIE_CP0_ADDR_W-1:0] CR_CAUSE    = {5'd13, 3'd0};
    localparam logic [VIE_CP0_ADDR_W-1:0] CR_EPC      = {5'd14, 3'd0};

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    localparam int EB_ADES    = 0;
    localparam int EB_ADEL    = 1;
    localparam int EB_BP      = 2;
    localparam int EB_SYS     = 3;
    localparam int EB_OV      = 4;
    localparam int EB_RI      = 5;
    localparam int EB_ADEL_IF = 6;

    // Fixed priority: Int > AdEL-if > RI > Ov > Sys > Bp > AdEL > AdES.
    function automatic exc_code_e exc_priority(input logic int_p, input logic [6:0] exc);
        if (int_p)                 return EXC_INT;
        else if (exc[EB_ADEL_IF])  return EXC_ADEL;
        else if (exc[EB_RI])       return EXC_RI;
        else if (exc[EB_OV])       return EXC_OV;
        else if (exc[EB_SYS])      return EXC_SYS;
        else if (exc[EB_BP])       return EXC_BP;
        else if (exc[EB_ADEL])     return EXC_ADEL;
        else if (exc[EB_ADES])     return EXC_ADES;
        else                       return EXC_INT;
    endfunction

endpackage

// File: rtl/vie_cp0_timer.sv
// CP0 timer: prescaler, Count, Compare and the sticky timer-interrupt flag.
module vie_cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    localparam int DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

    logic [DIV_W-1:0] div;

    // NOTE: non-blocking everywhere so the TI compare sees the pre-edge Count.
    always_ff @(posedge clock) begin
        if (reset) begin
            div     <= '0;
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            if (count_we) begin
                count <= wdata;
                div   <= '0;
            end else if (div == DIV_LAST) begin
                div   <= '0;
                count <= count + 32'd1;
            end else begin
                div   <= div + DIV_W'(1);
            end

            if (compare_we) compare <= wdata;

            if (compare_we)            ti <= 1'b0;
            else if (count == compare) ti <= 1'b1;
        end
    end

endmodule

// File: rtl/vie_cp0_unit.sv
// CP0 register file and precise-exception commit unit beside WB: resolves
// exceptions, interrupts, ERET and MTC0/MFC0, and issues the one-cycle flush.
module vie_cp0_unit
    import vie_cp0_pkg::*;
#(
    parameter int          N_EXT_INT  = 6,
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter bit          RESET_BEV  = 1'b1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_EXT_INT-1:0]      ext_int_in,
    input  logic                      commit_valid,
    input  logic [31:0]               commit_pc,
    input  logic                      commit_bd,
    input  logic [6:0]                commit_exc,
    input  logic [31:0]               commit_badva,
    input  logic                      commit_eret,
    input  logic                      commit_mtc0,
    input  logic [VIE_CP0_ADDR_W-1:0] cp0_addr,
    input  logic [31:0]               cp0_wdata,
    output logic [31:0]               cp0_rdata,
    output logic                      flush_o,
    output logic [31:0]               flush_target,
    output logic                      status_exl,
    output logic                      int_pending
);

    logic [7:0]  im;
    logic        exl, ie;
    logic [1:0]  ip_sw;
    logic [5:0]  ip_hw;
    logic        cause_bd;
    exc_code_e   exc_code;
    logic [31:0] epc, badvaddr;
    logic [31:0] count, compare;
    logic        ti;
    logic [5:0]  ext_pad;

    always_comb begin
        ext_pad = '0;
        ext_pad[N_EXT_INT-1:0] = ext_int_in;
    end

    assign int_pending = (|({ip_hw, ip_sw} & im)) && ie && !exl;
    assign status_exl  = exl;

    // An instruction arriving while flush_o is high is already squashed.
    logic      accepted, take_exc, do_eret, do_mtc0;
    exc_code_e exc_sel;

    assign accepted = commit_valid && !flush_o;
    assign take_exc = accepted && (int_pending || (|commit_exc));
    assign exc_sel  = exc_priority(int_pending, commit_exc);
    assign do_eret  = accepted && !take_exc && commit_eret;
    assign do_mtc0  = accepted && !take_exc && !commit_eret && commit_mtc0;

    vie_cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clock      (clock),
        .reset      (reset),
        .count_we   (do_mtc0 && (cp0_addr == CR_COUNT)),
        .compare_we (do_mtc0 && (cp0_addr == CR_COMPARE)),
        .wdata      (cp0_wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            im           <= '0;
            exl          <= 1'b0;
            ie           <= 1'b0;
            ip_sw        <= '0;
            ip_hw        <= '0;
            cause_bd     <= 1'b0;
            exc_code     <= EXC_INT;
            epc          <= '0;
            badvaddr     <= '0;
            flush_o      <= 1'b0;
            flush_target <= '0;
        end else begin
            flush_o <= take_exc || do_eret;
            ip_hw   <= {ext_pad[5] | ti, ext_pad[4:0]};

            if (take_exc) begin
                exc_code     <= exc_sel;
                exl          <= 1'b1;
                flush_target <= EXC_VECTOR;
                // A nested exception keeps the original return point.
                if (!exl) begin
                    epc      <= commit_bd ? commit_pc - 32'd4 : commit_pc;
                    cause_bd <= commit_bd;
                end
                if ((exc_sel == EXC_ADEL) || (exc_sel == EXC_ADES))
                    badvaddr <= commit_badva;
            end else if (do_eret) begin
                exl          <= 1'b0;
                flush_target <= epc;
            end else if (do_mtc0) begin
                case (cp0_addr)
                    CR_STATUS: begin
                        im  <= cp0_wdata[15:8];
                        exl <= cp0_wdata[1];
                        ie  <= cp0_wdata[0];
                    end
                    CR_CAUSE: ip_sw <= cp0_wdata[9:8];
                    CR_EPC:   epc   <= cp0_wdata;
                    default:  ;
                endcase
            end
        end
    end

    // NOTE: default assignment first so the read mux cannot infer a latch.
    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            CR_BADVADDR: cp0_rdata = badvaddr;
            CR_COUNT:    cp0_rdata = count;
            CR_COMPARE:  cp0_rdata = compare;
            CR_STATUS:   cp0_rdata = {9'b0, RESET_BEV, 6'b0, im, 6'b0, exl, ie};
            CR_CAUSE:    cp0_rdata = {cause_bd, ti, 14'b0, ip_hw, ip_sw, 1'b0, exc_code, 2'b0};
            CR_EPC:      cp0_rdata = epc;
            default:     cp0_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_vie_cp0_unit.sv
// Self-checking bench for vie_cp0_unit: spec-level reference model compared
// every cycle, plus directed scenarios with hand-computed values.
module tb_vie_cp0_unit;

    localparam int          N_EXT = 6;
    localparam int          CDIV  = 2;
    localparam logic [31:0] VEC   = 32'hBFC00380;

    localparam logic [7:0] A_BADVA   = 8'h40;
    localparam logic [7:0] A_COUNT   = 8'h48;
    localparam logic [7:0] A_COMPARE = 8'h58;
    localparam logic [7:0] A_STATUS  = 8'h60;
    localparam logic [7:0] A_CAUSE   = 8'h68;
    localparam logic [7:0] A_EPC     = 8'h70;

    logic             clock = 1'b0;
    logic             reset;
    logic [N_EXT-1:0] ext_int_in;
    logic             commit_valid;
    logic [31:0]      commit_pc;
    logic             commit_bd;
    logic [6:0]       commit_exc;
    logic [31:0]      commit_badva;
    logic             commit_eret;
    logic             commit_mtc0;
    logic [7:0]       cp0_addr;
    logic [31:0]      cp0_wdata;
    logic [31:0]      cp0_rdata;
    logic             flush_o;
    logic [31:0]      flush_target;
    logic             status_exl;
    logic             int_pending;

    vie_cp0_unit #(
        .N_EXT_INT (N_EXT),
        .COUNT_DIV (CDIV),
        .EXC_VECTOR(VEC),
        .RESET_BEV (1'b1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ext_int_in   (ext_int_in),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_bd    (commit_bd),
        .commit_exc   (commit_exc),
        .commit_badva (commit_badva),
        .commit_eret  (commit_eret),
        .commit_mtc0  (commit_mtc0),
        .cp0_addr     (cp0_addr),
        .cp0_wdata    (cp0_wdata),
        .cp0_rdata    (cp0_rdata),
        .flush_o      (flush_o),
        .flush_target (flush_target),
        .status_exl   (status_exl),
        .int_pending  (int_pending)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    bit          m_valid = 1'b0;
    logic [7:0]  m_im;
    logic        m_exl, m_ie, m_ti, m_bd, m_flush;
    logic [1:0]  m_ip_sw;
    logic [5:0]  m_ip_hw;
    logic [4:0]  m_exc;
    logic [31:0] m_epc, m_badva, m_compare, m_cnt_base, m_tgt;
    int          m_k;
    // ExcCode for each commit_exc bit; the highest set bit has priority.
    logic [4:0]  code_of_bit [0:6] = '{5'd5, 5'd4, 5'd9, 5'd8, 5'd12, 5'd10, 5'd4};

    function automatic logic [31:0] m_count();
        return m_cnt_base + 32'(m_k / CDIV);
    endfunction

    function automatic logic m_pend();
        return (|({m_ip_hw, m_ip_sw} & m_im)) && m_ie && !m_exl;
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        case (a)
            A_BADVA:   return m_badva;
            A_COUNT:   return m_count();
            A_COMPARE: return m_compare;
            A_STATUS:  return 32'h0040_0000 | {16'b0, m_im, 6'b0, m_exl, m_ie};
            A_CAUSE:   return {m_bd, m_ti, 14'b0, m_ip_hw, m_ip_sw, 1'b0, m_exc, 2'b0};
            A_EPC:     return m_epc;
            default:   return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        logic [31:0] cur;
        logic        pend, acc, take, mtc, eret, old_ti;
        logic [31:0] old_epc;
        logic [4:0]  code;
        if (reset) begin
            m_im = 0; m_exl = 0; m_ie = 0; m_ti = 0; m_bd = 0; m_flush = 0;
            m_ip_sw = 0; m_ip_hw = 0; m_exc = 0; m_epc = 0; m_badva = 0;
            m_compare = 0; m_cnt_base = 0; m_tgt = 0; m_k = 0; m_valid = 1'b1;
            return;
        end
        cur     = m_count();
        pend    = m_pend();
        acc     = commit_valid && !m_flush;
        take    = acc && (pend || (|commit_exc));
        eret    = acc && !take && commit_eret;
        mtc     = acc && !take && !commit_eret && commit_mtc0;
        old_ti  = m_ti;
        old_epc = m_epc;

        if (mtc && cp0_addr == A_COMPARE) begin m_compare = cp0_wdata; m_ti = 1'b0; end
        else if (cur == m_compare) m_ti = 1'b1;
        if (mtc && cp0_addr == A_COUNT) begin m_cnt_base = cp0_wdata; m_k = 0; end
        else m_k++;
        m_ip_hw = {ext_int_in[5] | old_ti, ext_int_in[4:0]};
        m_flush = take || eret;

        if (take) begin
            code = 5'd0;
            if (!pend)
                for (int i = 6; i >= 0; i--)
                    if (commit_exc[i]) begin code = code_of_bit[i]; break; end
            if (!m_exl) begin
                m_epc = commit_bd ? commit_pc - 32'd4 : commit_pc;
                m_bd  = commit_bd;
            end
            m_exl = 1'b1;
            m_exc = code;
            if (code == 5'd4 || code == 5'd5) m_badva = commit_badva;
            m_tgt = VEC;
        end else if (eret) begin
            m_exl = 1'b0;
            m_tgt = old_epc;
        end else if (mtc) begin
            case (cp0_addr)
                A_STATUS: begin m_im = cp0_wdata[15:8]; m_exl = cp0_wdata[1]; m_ie = cp0_wdata[0]; end
                A_CAUSE:  m_ip_sw = cp0_wdata[9:8];
                A_EPC:    m_epc = cp0_wdata;
                default:  ;
            endcase
        end
    endtask

    always @(posedge clock) model_step();

    always @(negedge clock) begin
        if (m_valid && !reset) begin
            check("flush_o", {31'b0, flush_o}, {31'b0, m_flush});
            check("status_exl", {31'b0, status_exl}, {31'b0, m_exl});
            check("int_pending", {31'b0, int_pending}, {31'b0, m_pend()});
            check("cp0_rdata", cp0_rdata, m_read(cp0_addr));
            if (m_flush) check("flush_target", flush_target, m_tgt);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        commit_valid = 0; commit_pc = 0; commit_bd = 0; commit_exc = 0;
        commit_badva = 0; commit_eret = 0; commit_mtc0 = 0; cp0_wdata = 0;
    endtask

    task automatic commit(input logic [31:0] pc, input logic bd, input logic [6:0] exc,
                          input logic [31:0] badva, input logic eret, input logic mtc0,
                          input logic [7:0] addr, input logic [31:0] wdata);
        commit_valid = 1; commit_pc = pc; commit_bd = bd; commit_exc = exc;
        commit_badva = badva; commit_eret = eret; commit_mtc0 = mtc0;
        cp0_addr = addr; cp0_wdata = wdata;
        @(posedge clock); #1;
        idle();
    endtask

    task automatic mtc0(input logic [7:0] addr, input logic [31:0] wdata);
        commit(32'h8000_0F00, 1'b0, 7'b0, 32'h0, 1'b0, 1'b1, addr, wdata);
    endtask

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        cp0_addr = a;
        @(negedge clock); #1;
        d = cp0_rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        reset = 1; ext_int_in = '0; cp0_addr = 8'h00; idle();
        repeat (3) @(posedge clock);
        #1 reset = 0;

        // Reset state
        check("rst_flush", {31'b0, flush_o}, 32'h0);
        rd(A_STATUS, d); check("rst_status", d, 32'h0040_0000);
        rd(A_EPC, d);    check("rst_epc", d, 32'h0);

        // Syscall
        commit(32'hBFC0_0100, 1'b0, 7'b0001000, 32'h0, 1'b0, 1'b0, A_EPC, 32'h0);
        check("sys_flush", {31'b0, flush_o}, 32'h1);
        check("sys_target", flush_target, 32'hBFC0_0380);
        check("sys_exl", {31'b0, status_exl}, 32'h1);
        step();
        rd(A_EPC, d);   check("sys_epc", d, 32'hBFC0_0100);
        rd(A_CAUSE, d); check("sys_code", (d >> 2) & 32'h1F, 32'd8);

        // ERET, then a commit in the flush cycle is squashed
        mtc0(A_EPC, 32'hBFC0_0120);
        commit(32'h8000_0000, 1'b0, 7'b0, 32'h0, 1'b1, 1'b0, A_EPC, 32'h0);
        check("eret_flush", {31'b0, flush_o}, 32'h1);
        check("eret_target", flush_target, 32'hBFC0_0120);
        check("eret_exl", {31'b0, status_exl}, 32'h0);
        commit(32'h1234_5678, 1'b0, 7'b0001000, 32'h0, 1'b0, 1'b0, A_EPC, 32'h0);
        check("squash_flush", {31'b0, flush_o}, 32'h0);
        check("squash_exl", {31'b0, status_exl}, 32'h0);
        rd(A_EPC, d); check("squash_epc", d, 32'hBFC0_0120);

        // AdEL in a delay slot
        commit(32'hBFC0_0204, 1'b1, 7'b0000010, 32'h0000_0003, 1'b0, 1'b0, A_EPC, 32'h0);
        check("adel_flush", {31'b0, flush_o}, 32'h1);
        step();
        rd(A_EPC, d);   check("adel_epc", d, 32'hBFC0_0200);
        rd(A_CAUSE, d); check("adel_bd", d >> 31, 32'h1);
        check("adel_code", (d >> 2) & 32'h1F, 32'd4);
        rd(A_BADVA, d); check("adel_badva", d, 32'h3);

        // Nested exception (RI beats Bp): EPC/BD kept
        commit(32'h8000_1000, 1'b0, 7'b0100100, 32'h0, 1'b0, 1'b0, A_EPC, 32'h0);
        check("nest_target", flush_target, VEC);
        step();
        rd(A_EPC, d);   check("nest_epc", d, 32'hBFC0_0200);
        rd(A_CAUSE, d); check("nest_code", (d >> 2) & 32'h1F, 32'd10);
        check("nest_bd", d >> 31, 32'h1);

        // Timer interrupt
        mtc0(A_COMPARE, 32'd5);
        mtc0(A_COUNT, 32'd0);
        mtc0(A_STATUS, 32'h0000_8001);
        for (int i = 0; i < 40 && !int_pending; i++) step();
        check("timer_irq", {31'b0, int_pending}, 32'h1);
        rd(A_COUNT, d); check("timer_count", d, 32'd6);
        commit(32'h8000_2000, 1'b0, 7'b0, 32'h0, 1'b0, 1'b0, A_EPC, 32'h0);
        check("int_flush", {31'b0, flush_o}, 32'h1);
        check("int_target", flush_target, VEC);
        step();
        rd(A_CAUSE, d); check("int_code", (d >> 2) & 32'h1F, 32'd0);
        rd(A_EPC, d);   check("int_epc", d, 32'h8000_2000);
        mtc0(A_COMPARE, 32'h0000_1000);
        rd(A_CAUSE, d); check("ti_clear", (d >> 30) & 32'h1, 32'h0);

        // ERET, then MTC0 Status together with RI
        commit(32'h8000_0000, 1'b0, 7'b0, 32'h0, 1'b1, 1'b0, A_EPC, 32'h0);
        check("eret2_target", flush_target, 32'h8000_2000);
        step();
        commit(32'h8000_3000, 1'b0, 7'b0100000, 32'h0, 1'b0, 1'b1, A_STATUS, 32'h0000_FF00);
        check("ri_flush", {31'b0, flush_o}, 32'h1);
        step();
        rd(A_STATUS, d); check("ri_status", d, 32'h0040_8003);
        rd(A_CAUSE, d);  check("ri_code", (d >> 2) & 32'h1F, 32'd10);
        rd(A_EPC, d);    check("ri_epc", d, 32'h8000_3000);

        // External interrupt lines and software bits
        ext_int_in = 6'b000001; step(); step();
        rd(A_CAUSE, d); check("ext_ip2", d & 32'h0000_FC00, 32'h0000_0400);
        ext_int_in = 6'b100000; step(); step();
        rd(A_CAUSE, d); check("ext_ip7", d & 32'h0000_FC00, 32'h0000_8000);
        ext_int_in = '0;
        mtc0(A_CAUSE, 32'h0000_0300);
        rd(A_CAUSE, d); check("sw_ip", d & 32'h0000_0300, 32'h0000_0300);
        mtc0(A_BADVA, 32'h0000_1234);
        rd(A_BADVA, d); check("badva_ro", d, 32'h3);

        // Count wrap
        mtc0(A_COUNT, 32'hFFFF_FFFF);
        step(); step();
        rd(A_COUNT, d); check("count_wrap", d, 32'h0);
        rd(8'h78, d); check("unmapped", d, 32'h0);
        rd(8'h49, d); check("bad_sel", d, 32'h0);

        // Reset during a flush
        commit(32'h8000_4000, 1'b0, 7'b0001000, 32'h0, 1'b0, 1'b0, A_EPC, 32'h0);
        check("pre_rst_flush", {31'b0, flush_o}, 32'h1);
        reset = 1;
        step();
        check("rst_mid_flush", {31'b0, flush_o}, 32'h0);
        rd(A_STATUS, d); check("rst_mid_status", d, 32'h0040_0000);
        reset = 0;
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
